// File: rtl/iomem_gpio_pwm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : iomem_gpio_pwm_pkg
// Description : Shared definitions for the iomem GPIO/PWM peripheral:
//               register offsets, channel mode encoding, ID constants and
//               a byte-strobe merge helper.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package iomem_gpio_pwm_pkg;

    // Register offsets within the selected iomem region (addr[7:0]).
    localparam logic [7:0] OFS_OUT        = 8'h00;
    localparam logic [7:0] OFS_MODE       = 8'h04;
    localparam logic [7:0] OFS_PRESC      = 8'h08;
    localparam logic [7:0] OFS_ID         = 8'h0C;
    localparam logic [7:0] OFS_LEVEL_BASE = 8'h40;

    // Identification word fields.
    localparam logic [7:0] ID_MAGIC   = 8'hA5;
    localparam logic [7:0] ID_VERSION = 8'h01;

    // Per-channel operating mode, 2 bits per channel in the MODE register.
    typedef enum logic [1:0] {
        MODE_OFF    = 2'd0,
        MODE_DIRECT = 2'd1,
        MODE_BLINK  = 2'd2,
        MODE_PWM    = 2'd3
    } ch_mode_e;

    // Replace the bytes of 'cur' selected by 'wstrb' with those of 'wdata'.
    function automatic logic [31:0] merge_bytes(
        input logic [31:0] cur,
        input logic [31:0] wdata,
        input logic [3:0]  wstrb
    );
        logic [31:0] res;
        res = cur;
        for (int b = 0; b < 4; b++) begin
            if (wstrb[b]) begin
                res[8*b +: 8] = wdata[8*b +: 8];
            end
        end
        return res;
    endfunction

endpackage : iomem_gpio_pwm_pkg
`default_nettype wire

// File: rtl/gpio_pwm_channel.sv
`default_nettype none
// ============================================================================
// Module      : gpio_pwm_channel
// Description : One output channel of the GPIO/PWM peripheral. Holds the
//               blink counter and blink state, and produces a registered
//               output selected by the channel mode.
// Ports       : clk, resetn     - clock, async active-low reset
//               mode[1:0]       - OFF / DIRECT / BLINK / PWM
//               level[PWM_W-1:0]- PWM duty or blink half-period minus one
//               out_bit         - DIRECT-mode data bit
//               pwm_cnt         - shared PWM base counter
//               tick            - shared prescaler tick
//               clr             - restart blink phase (config write)
//               out             - registered channel output
// Revision    : 1.0 - initial release
// ============================================================================
module gpio_pwm_channel
    import iomem_gpio_pwm_pkg::*;
#(
    parameter int PWM_W = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [1:0]       mode,
    input  logic [PWM_W-1:0] level,
    input  logic             out_bit,
    input  logic [PWM_W-1:0] pwm_cnt,
    input  logic             tick,
    input  logic             clr,
    output logic             out
);

    logic [PWM_W-1:0] bcnt;
    logic             blink;
    logic             out_next;

    // Blink timebase: toggles after (level+1) ticks. A configuration write
    // takes priority over a coincident tick so the phase restarts cleanly
    // from low.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            bcnt  <= '0;
            blink <= 1'b0;
        end else if (clr) begin
            bcnt  <= '0;
            blink <= 1'b0;
        end else if (tick) begin
            if (bcnt == level) begin
                bcnt  <= '0;
                blink <= ~blink;
            end else begin
                bcnt  <= bcnt + 1'b1;
            end
        end
    end

    always_comb begin
        out_next = 1'b0;
        case (ch_mode_e'(mode))
            MODE_OFF:    out_next = 1'b0;
            MODE_DIRECT: out_next = out_bit;
            MODE_BLINK:  out_next = blink;
            MODE_PWM:    out_next = (pwm_cnt < level);
            default:     out_next = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            out <= 1'b0;
        end else begin
            out <= out_next;
        end
    end

endmodule : gpio_pwm_channel
`default_nettype wire

// File: rtl/iomem_gpio_pwm.sv
`default_nettype none
// ============================================================================
// Module      : iomem_gpio_pwm
// Description : Parametrised GPIO/LED peripheral on the picosoc iomem bus.
//               NUM_CH channels, each OFF / DIRECT / BLINK / PWM, sharing a
//               programmable prescaler and a free-running PWM base counter.
// Ports       : clk, resetn            - clock, async active-low reset
//               iomem_valid/ready      - request / one-cycle acknowledge
//               iomem_wstrb[3:0]       - byte write strobes, 0 = read
//               iomem_addr[31:0]       - byte address, [31:24] = region
//               iomem_wdata[31:0]      - write data
//               iomem_rdata[31:0]      - read data, valid with ready
//               gpio_out[NUM_CH-1:0]   - registered channel outputs
// Revision    : 1.0 - initial release
// ============================================================================
module iomem_gpio_pwm
    import iomem_gpio_pwm_pkg::*;
#(
    parameter int         NUM_CH      = 8,
    parameter int         PWM_W       = 8,
    parameter int         PRESC_W     = 16,
    parameter int         PRESC_RESET = 15,
    parameter logic [7:0] BASE_ADDR   = 8'h03
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              iomem_valid,
    output logic              iomem_ready,
    input  logic [3:0]        iomem_wstrb,
    input  logic [31:0]       iomem_addr,
    input  logic [31:0]       iomem_wdata,
    output logic [31:0]       iomem_rdata,
    output logic [NUM_CH-1:0] gpio_out
);

    // ------------------------------------------------------------------
    // Register state
    // ------------------------------------------------------------------
    logic [NUM_CH-1:0]   out_reg;
    logic [2*NUM_CH-1:0] mode_reg;
    logic [PRESC_W-1:0]  presc_reg;
    logic [PWM_W-1:0]    level_reg [NUM_CH];

    logic [PRESC_W-1:0]  pcnt;
    logic [PWM_W-1:0]    pwm_cnt;
    logic                tick;

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    logic              sel;
    logic              wr;
    logic [7:0]        offset;
    logic              hit_out;
    logic              hit_mode;
    logic              hit_presc;
    logic              hit_id;
    logic [NUM_CH-1:0] hit_level;
    logic [NUM_CH-1:0] ch_clr;
    logic [31:0]       rd_word;
    logic [31:0]       wr_word;

    // The !iomem_ready term makes each request acknowledge exactly once
    // even while the master is still holding valid on the ack cycle.
    assign sel    = iomem_valid && !iomem_ready && (iomem_addr[31:24] == BASE_ADDR);
    assign wr     = sel && (iomem_wstrb != 4'b0000);
    assign offset = {iomem_addr[7:2], 2'b00};

    assign hit_out   = (offset == OFS_OUT);
    assign hit_mode  = (offset == OFS_MODE);
    assign hit_presc = (offset == OFS_PRESC);
    assign hit_id    = (offset == OFS_ID);

    generate
        for (genvar i = 0; i < NUM_CH; i++) begin : g_dec
            localparam logic [7:0] LVL_OFS = 8'(32'(OFS_LEVEL_BASE) + 4 * i);
            assign hit_level[i] = (offset == LVL_OFS);
            // A MODE write restarts a channel only if its byte lane is
            // written; channel i's mode bits live in byte (2i)/8.
            assign ch_clr[i] = wr && (hit_level[i] || (hit_mode && iomem_wstrb[(2 * i) / 8]));
        end
    endgenerate

    // Read mux: unused bits and unmapped offsets return 0. The same word
    // is the base for byte merging, so partial writes keep other bytes.
    always_comb begin
        rd_word = '0;
        if (hit_out) begin
            rd_word[NUM_CH-1:0] = out_reg;
        end
        if (hit_mode) begin
            rd_word[2*NUM_CH-1:0] = mode_reg;
        end
        if (hit_presc) begin
            rd_word[PRESC_W-1:0] = presc_reg;
        end
        if (hit_id) begin
            rd_word = {ID_MAGIC, 8'(PWM_W), 8'(NUM_CH), ID_VERSION};
        end
        for (int i = 0; i < NUM_CH; i++) begin
            if (hit_level[i]) begin
                rd_word[PWM_W-1:0] = level_reg[i];
            end
        end
    end

    assign wr_word = merge_bytes(rd_word, iomem_wdata, iomem_wstrb);

    // ------------------------------------------------------------------
    // Bus handshake: one-cycle ack, rdata captured with the pre-write value
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            iomem_ready <= 1'b0;
            iomem_rdata <= '0;
        end else begin
            iomem_ready <= sel;
            if (sel) begin
                iomem_rdata <= rd_word;
            end
        end
    end

    // ------------------------------------------------------------------
    // Register writes
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            out_reg   <= '0;
            mode_reg  <= '0;
            presc_reg <= PRESC_W'(PRESC_RESET);
            for (int i = 0; i < NUM_CH; i++) begin
                level_reg[i] <= '0;
            end
        end else if (wr) begin
            if (hit_out) begin
                out_reg <= wr_word[NUM_CH-1:0];
            end
            if (hit_mode) begin
                mode_reg <= wr_word[2*NUM_CH-1:0];
            end
            if (hit_presc) begin
                presc_reg <= wr_word[PRESC_W-1:0];
            end
            for (int i = 0; i < NUM_CH; i++) begin
                if (hit_level[i]) begin
                    level_reg[i] <= wr_word[PWM_W-1:0];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Prescaler and PWM base counter
    // ------------------------------------------------------------------
    assign tick = (pcnt == presc_reg);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pcnt    <= '0;
            pwm_cnt <= '0;
        end else begin
            // Reprogramming the divider restarts its phase so the new
            // period takes effect from a known point.
            if ((wr && hit_presc) || tick) begin
                pcnt <= '0;
            end else begin
                pcnt <= pcnt + 1'b1;
            end
            if (tick) begin
                pwm_cnt <= pwm_cnt + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Channels
    // ------------------------------------------------------------------
    generate
        for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
            gpio_pwm_channel #(
                .PWM_W (PWM_W)
            ) u_ch (
                .clk     (clk),
                .resetn  (resetn),
                .mode    (mode_reg[2*i +: 2]),
                .level   (level_reg[i]),
                .out_bit (out_reg[i]),
                .pwm_cnt (pwm_cnt),
                .tick    (tick),
                .clr     (ch_clr[i]),
                .out     (gpio_out[i])
            );
        end
    endgenerate

    // Address bits outside the region select and word offset do not
    // participate in decode; upper merge bits beyond each field are dropped.
    logic unused_bits;
    assign unused_bits = ^{iomem_addr[23:8], iomem_addr[1:0], wr_word};

endmodule : iomem_gpio_pwm
`default_nettype wire

// File: tb/tb_iomem_gpio_pwm.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_iomem_gpio_pwm
// Description : Self-checking bench for iomem_gpio_pwm. A register-level
//               reference model predicts every bus read; channel outputs are
//               checked against duty-cycle and blink-period rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_iomem_gpio_pwm;

    localparam int NUM_CH = 8;
    localparam int PWM_W  = 8;

    logic              clk         = 1'b0;
    logic              resetn      = 1'b0;
    logic              iomem_valid = 1'b0;
    logic              iomem_ready;
    logic [3:0]        iomem_wstrb = 4'b0000;
    logic [31:0]       iomem_addr  = 32'h0;
    logic [31:0]       iomem_wdata = 32'h0;
    logic [31:0]       iomem_rdata;
    logic [NUM_CH-1:0] gpio_out;

    always #5 clk = ~clk;

    iomem_gpio_pwm #(
        .NUM_CH      (NUM_CH),
        .PWM_W       (PWM_W),
        .PRESC_W     (16),
        .PRESC_RESET (15),
        .BASE_ADDR   (8'h03)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .iomem_valid (iomem_valid),
        .iomem_ready (iomem_ready),
        .iomem_wstrb (iomem_wstrb),
        .iomem_addr  (iomem_addr),
        .iomem_wdata (iomem_wdata),
        .iomem_rdata (iomem_rdata),
        .gpio_out    (gpio_out)
    );

    int total = 0;
    int bad   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Register reference model
    // ------------------------------------------------------------------
    logic [7:0]  m_out;
    logic [15:0] m_mode;
    logic [15:0] m_presc;
    logic [7:0]  m_level [NUM_CH];

    task automatic m_reset();
        m_out   = 8'h00;
        m_mode  = 16'h0000;
        m_presc = 16'd15;
        for (int i = 0; i < NUM_CH; i++) m_level[i] = 8'h00;
    endtask

    function automatic logic [31:0] m_read(input logic [7:0] ofs);
        logic [7:0] o;
        int idx;
        o = {ofs[7:2], 2'b00};
        if (o == 8'h00) return {24'h0, m_out};
        if (o == 8'h04) return {16'h0, m_mode};
        if (o == 8'h08) return {16'h0, m_presc};
        if (o == 8'h0C) return 32'hA5080801;
        if (o >= 8'h40 && o < 8'h60) begin
            idx = (int'(o) - 'h40) / 4;
            return {24'h0, m_level[idx]};
        end
        return 32'h0;
    endfunction

    task automatic m_write(input logic [7:0] ofs, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] w;
        logic [7:0]  o;
        int idx;
        o = {ofs[7:2], 2'b00};
        w = m_read(o);
        for (int b = 0; b < 4; b++) if (s[b]) w[8*b +: 8] = d[8*b +: 8];
        if (o == 8'h00) m_out = w[7:0];
        else if (o == 8'h04) m_mode = w[15:0];
        else if (o == 8'h08) m_presc = w[15:0];
        else if (o >= 8'h40 && o < 8'h60) begin
            idx = (int'(o) - 'h40) / 4;
            m_level[idx] = w[7:0];
        end
    endtask

    // ------------------------------------------------------------------
    // Bus access: bounded wait for ack; valid is held through the ack
    // cycle so a second ack would be visible.
    // ------------------------------------------------------------------
    task automatic bus_xfer(input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] wstrb, output logic [31:0] rd, output bit acked);
        @(negedge clk);
        iomem_valid = 1'b1;
        iomem_addr  = addr;
        iomem_wdata = wdata;
        iomem_wstrb = wstrb;
        acked = 1'b0;
        rd    = 32'h0;
        for (int n = 0; n < 8 && !acked; n++) begin
            @(posedge clk); #1;
            if (iomem_ready) begin
                acked = 1'b1;
                rd    = iomem_rdata;
            end
        end
        if (acked) begin
            @(posedge clk); #1;
            check_val("ready_width", {31'b0, iomem_ready}, 32'h0);
        end
        iomem_valid = 1'b0;
        iomem_wstrb = 4'b0000;
    endtask

    // Transaction checked against the model: ack expected, rdata = pre-write.
    task automatic xact(input logic [31:0] addr, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] exp, rd;
        bit acked;
        exp = m_read(addr[7:0]);
        bus_xfer(addr, d, s, rd, acked);
        check_val($sformatf("ack@%h", addr), {31'b0, acked}, 32'h1);
        check_val($sformatf("rdata@%h", addr), rd, exp);
        if (s != 4'b0000) m_write(addr[7:0], d, s);
    endtask

    task automatic wr_reg(input logic [7:0] ofs, input logic [31:0] d, input logic [3:0] s);
        xact({8'h03, 16'h0000, ofs}, d, s);
    endtask

    task automatic rd_reg(input logic [7:0] ofs);
        xact({8'h03, 16'h0000, ofs}, 32'hDEAD_BEEF, 4'b0000);
    endtask

    task automatic rd_all();
        rd_reg(8'h00); rd_reg(8'h04); rd_reg(8'h08); rd_reg(8'h0C);
        for (int i = 0; i < NUM_CH; i++) rd_reg(8'(8'h40 + 4 * i));
    endtask

    task automatic cycles(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Cycles until gpio_out[ch] == val, bounded.
    task automatic wait_ch(input int ch, input logic val, input int bound, output int cyc);
        cyc = 0;
        while (gpio_out[ch] !== val && cyc < bound) begin
            @(posedge clk); #1;
            cyc++;
        end
        if (gpio_out[ch] !== val)
            check_val($sformatf("timeout_ch%0d", ch), {31'b0, gpio_out[ch]}, {31'b0, val});
    endtask

    logic [7:0] ofs_tab [12] = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h20,
                                 8'h3C, 8'h40, 8'h44, 8'h5C, 8'h60, 8'hFC};

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cnt, h, l, p, lv, cyc;
        logic [7:0]  ofs;
        logic [31:0] rd;
        bit acked;
        int lv_tab [4];

        // ---------------- reset state ----------------
        m_reset();
        cycles(3);
        check_val("rst_ready", {31'b0, iomem_ready}, 32'h0);
        check_val("rst_rdata", iomem_rdata, 32'h0);
        check_val("rst_gpio", {24'h0, gpio_out}, 32'h0);
        @(negedge clk);
        resetn = 1'b1;
        cycles(2);
        rd_reg(8'h0C);
        rd_reg(8'h08);
        check_val("gpio_after_rst", {24'h0, gpio_out}, 32'h0);

        // ---------------- DIRECT mode ----------------
        wr_reg(8'h00, 32'h0000_005A, 4'b1111);
        wr_reg(8'h04, 32'h0000_5555, 4'b1111);
        check_val("direct_5a", {24'h0, gpio_out}, {24'h0, m_out});
        rd_reg(8'h00);
        rd_reg(8'h00);

        // MODE byte-lane write affects channels 4..7 only
        wr_reg(8'h04, 32'h0, 4'b1111);
        wr_reg(8'h00, 32'hFF, 4'b0001);
        wr_reg(8'h04, 32'hFFFF_5555, 4'b0010);
        check_val("mode_lane1_gpio", {24'h0, gpio_out}, 32'h0000_00F0);
        rd_reg(8'h04);

        // ---------------- randomized register traffic ----------------
        for (int it = 0; it < 40; it++) begin
            ofs = ofs_tab[$urandom_range(0, 11)];
            if (ofs >= 8'h40 && ofs < 8'h60) ofs = 8'(8'h40 + 4 * $urandom_range(0, 7));
            ofs[1:0] = 2'($urandom_range(0, 3));
            xact({8'h03, 16'($urandom), ofs}, $urandom, 4'($urandom_range(0, 15)));
        end
        rd_all();

        // ---------------- PWM duty ----------------
        wr_reg(8'h08, 32'h0, 4'b1111);
        wr_reg(8'h04, 32'h3, 4'b1111);
        lv_tab = '{64, 0, 255, int'($urandom_range(1, 254))};
        for (int k = 0; k < 4; k++) begin
            wr_reg(8'h40, 32'(lv_tab[k]), 4'b0001);
            cycles(4);
            cnt = 0;
            for (int c = 0; c < 256; c++) begin
                @(posedge clk); #1;
                cnt += int'(gpio_out[0]);
            end
            check_val($sformatf("pwm_high_lv%0d", lv_tab[k]), 32'(cnt), 32'(lv_tab[k]));
        end

        // ---------------- BLINK period ----------------
        for (int k = 0; k < 3; k++) begin
            p  = (k == 0) ? 3 : int'($urandom_range(0, 3));
            lv = (k == 0) ? 1 : int'($urandom_range(0, 5));
            wr_reg(8'h08, 32'(p), 4'b0011);
            wr_reg(8'h04, 32'h20, 4'b0001);
            wr_reg(8'h48, 32'(lv), 4'b0001);
            wait_ch(2, 1'b0, 400, cyc);
            wait_ch(2, 1'b1, 400, cyc);
            wait_ch(2, 1'b0, 400, h);
            wait_ch(2, 1'b1, 400, l);
            check_val($sformatf("blink_high_p%0d_l%0d", p, lv), 32'(h), 32'((lv + 1) * (p + 1)));
            check_val($sformatf("blink_low_p%0d_l%0d", p, lv), 32'(l), 32'((lv + 1) * (p + 1)));
        end

        // Rewriting LEVEL mid-period restarts the phase from low
        wr_reg(8'h08, 32'd3, 4'b0011);
        wr_reg(8'h48, 32'd7, 4'b0001);
        wait_ch(2, 1'b1, 400, cyc);
        wr_reg(8'h48, 32'd7, 4'b0001);
        check_val("blink_restart_low", {31'b0, gpio_out[2]}, 32'h0);
        wait_ch(2, 1'b1, 400, cyc);
        wait_ch(2, 1'b0, 400, h);
        check_val("blink_restart_high", 32'(h), 32'd32);

        // ---------------- decode boundaries ----------------
        bus_xfer(32'h0400_0000, 32'hFFFF_FFFF, 4'b1111, rd, acked);
        check_val("wrong_base_noack", {31'b0, acked}, 32'h0);
        wr_reg(8'h20, $urandom, 4'b1111);
        rd_reg(8'h20);
        rd_all();

        // ---------------- asynchronous reset mid-activity ----------------
        wr_reg(8'h08, 32'h0, 4'b0011);
        wr_reg(8'h00, 32'hFF, 4'b0001);
        wr_reg(8'h40, 32'hFF, 4'b0001);
        wr_reg(8'h48, 32'h0, 4'b0001);
        wr_reg(8'h04, 32'h5567, 4'b0011);
        cycles(3);
        check_val("pre_rst_direct", {26'h0, gpio_out[7:3], gpio_out[1]}, 32'h3F);
        @(negedge clk);
        iomem_valid = 1'b1;
        iomem_addr  = 32'h0300_000C;
        iomem_wstrb = 4'b0000;
        @(posedge clk); #2;
        check_val("pre_rst_ready", {31'b0, iomem_ready}, 32'h1);
        resetn = 1'b0;
        #1;
        check_val("async_rst_ready", {31'b0, iomem_ready}, 32'h0);
        check_val("async_rst_gpio", {24'h0, gpio_out}, 32'h0);
        check_val("async_rst_rdata", iomem_rdata, 32'h0);
        iomem_valid = 1'b0;
        cycles(3);
        @(negedge clk);
        resetn = 1'b1;
        m_reset();
        cycles(2);
        check_val("post_rst_gpio", {24'h0, gpio_out}, 32'h0);
        rd_all();
        cycles(40);
        check_val("post_rst_gpio_idle", {24'h0, gpio_out}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_iomem_gpio_pwm
`default_nettype wire
